rv32_multicycle_controller: RTL and testbench

Multi-cycle successor to the single-cycle RV32 control unit. It is a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback over several clocks for a shared-memory multi-cycle datapath. It supports a ready handshake to variable-latency memory and flags illegal instructions. It sits between the instruction register / flag outputs of the datapath and all datapath mux, enable and ALU controls.

---
 rtl/rv_ctrl_pkg.sv | 58 +++++
 rtl/rv32_multicycle_controller_if.sv | 34 +++
 rtl/rv_alu_decoder.sv | 33 +++
 rtl/rv32_multicycle_controller.sv | 184 ++++++++++++++++++
 tb/tb_rv32_multicycle_controller.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 controller: opcodes, ALU codes,
// datapath mux selects, immediate formats and the FSM state type.
package rv_ctrl_pkg;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;

    localparam logic [2:0] AluAnd = 3'd0;
    localparam logic [2:0] AluOr  = 3'd1;
    localparam logic [2:0] AluAdd = 3'd3;
    localparam logic [2:0] AluXor = 3'd4;
    localparam logic [2:0] AluSub = 3'd6;
    localparam logic [2:0] AluSlt = 3'd7;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;
    localparam logic [1:0] SrcAZero  = 2'b11;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut = 2'b00;
    localparam logic [1:0] ResRdata  = 2'b01;
    localparam logic [1:0] ResAlu    = 2'b10;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StExecR    = 4'd2,
        StExecI    = 4'd3,
        StAluWb    = 4'd4,
        StMemAdr   = 4'd5,
        StMemRead  = 4'd6,
        StMemWb    = 4'd7,
        StMemWrite = 4'd8,
        StBranch   = 4'd9,
        StJalrAdr  = 4'd10,
        StJal      = 4'd11,
        StLui      = 4'd12,
        StIllegal  = 4'd13,
        StTrap     = 4'd14
    } state_e;

endpackage

// File: rtl/rv32_multicycle_controller_if.sv
// Controller <-> datapath bundle: IR/flags/ready in, all control strobes out.
interface rv32_multicycle_controller_if #(
    parameter int unsigned ALUCW = 3
) ();
    logic [31:0]      instr;
    logic             zero;
    logic             lt;
    logic             mem_ready;
    logic             mem_req;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       res_src;
    logic [2:0]       imm_src;
    logic [ALUCW-1:0] alu_control;
    logic             illegal;
    logic [3:0]       state_o;

    modport master (
        input  instr, zero, lt, mem_ready,
        output mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, res_src, imm_src, alu_control, illegal, state_o
    );

    modport slave (
        output instr, zero, lt, mem_ready,
        input  mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, res_src, imm_src, alu_control, illegal, state_o
    );
endinterface

// File: rtl/rv_alu_decoder.sv
// Maps funct3/funct7[5] to an ALU operation; flags combinations outside the
// supported add/sub/and/or/xor/slt set.
module rv_alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic       op_is_r_i,
    output logic [2:0] alu_code_o,
    output logic       illegal_o
);
    logic sub_sel;

    assign sub_sel = op_is_r_i & funct7b5_i;

    always_comb begin
        alu_code_o = AluAnd;
        illegal_o  = 1'b0;
        case (funct3_i)
            3'b000:  alu_code_o = sub_sel ? AluSub : AluAdd;
            3'b010:  alu_code_o = AluSlt;
            3'b100:  alu_code_o = AluXor;
            3'b110:  alu_code_o = AluOr;
            3'b111:  alu_code_o = AluAnd;
            default: illegal_o  = 1'b1;
        endcase
        // funct7[5] only selects sub; on any other R-type op it is unsupported
        if (sub_sel && funct3_i != 3'b000) begin
            alu_code_o = AluAnd;
            illegal_o  = 1'b1;
        end
    end
endmodule

// File: rtl/rv32_multicycle_controller.sv
// Multi-cycle RV32 control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every datapath mux select, write enable and ALU control.
module rv32_multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter bit          MEM_WAIT        = 1'b1,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1,
    parameter int unsigned ALUCW           = 3
) (
    input  logic clk,
    input  logic rst_n,
    rv32_multicycle_controller_if.master bus
);
    state_e     state_q, state_d, bad_st;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       ready, taken, br_ok;
    logic [2:0] dec_code;
    logic       dec_illegal;
    logic       mem_req, adr_src, mem_write, ir_write, pc_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, res_src;
    logic [2:0] imm_src, alu_code;
    logic       unused_instr;

    assign opcode       = bus.instr[6:0];
    assign funct3       = bus.instr[14:12];
    assign unused_instr = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};
    assign ready        = MEM_WAIT ? bus.mem_ready : 1'b1;
    assign bad_st       = TRAP_ON_ILLEGAL ? StTrap : StIllegal;

    rv_alu_decoder u_alu_dec (
        .funct3_i   (funct3),
        .funct7b5_i (bus.instr[30]),
        .op_is_r_i  (opcode == OpR),
        .alu_code_o (dec_code),
        .illegal_o  (dec_illegal)
    );

    always_comb begin
        taken = 1'b0;
        br_ok = 1'b1;
        case (funct3)
            3'b000:  taken = bus.zero;
            3'b001:  taken = ~bus.zero;
            3'b100:  taken = bus.lt;
            3'b101:  taken = ~bus.lt;
            default: br_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StFetch;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        adr_src   = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        alu_src_a = SrcAPc;
        alu_src_b = SrcBRs2;
        res_src   = ResAluOut;
        imm_src   = ImmI;
        alu_code  = AluAnd;
        unique case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = SrcBFour;
                alu_code  = AluAdd;
                res_src   = ResAlu;
                ir_write  = ready;
                pc_write  = ready;
                if (ready) state_d = StDecode;
            end
            StDecode: begin
                // Branch/jump target is precomputed into ALUOut here
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
                alu_code  = AluAdd;
                imm_src   = (opcode == OpJal) ? ImmJ : ImmB;
                case (opcode)
                    OpR:             state_d = StExecR;
                    OpI:             state_d = StExecI;
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalrAdr;
                    OpLui:           state_d = StLui;
                    default:         state_d = bad_st;
                endcase
            end
            StExecR, StExecI: begin
                alu_src_a = SrcARs1;
                alu_src_b = (state_q == StExecR) ? SrcBRs2 : SrcBImm;
                alu_code  = dec_code;
                state_d   = dec_illegal ? bad_st : StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_code  = AluAdd;
                imm_src   = (opcode == OpStore) ? ImmS : ImmI;
                if (funct3 != 3'b010)       state_d = bad_st;
                else if (opcode == OpStore) state_d = StMemWrite;
                else                        state_d = StMemRead;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (ready) state_d = StMemWb;
            end
            StMemWb: begin
                res_src   = ResRdata;
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ready) state_d = StFetch;
            end
            StBranch: begin
                alu_src_a = SrcARs1;
                alu_code  = AluSub;
                pc_write  = taken & br_ok;
                state_d   = br_ok ? StFetch : bad_st;
            end
            StJalrAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_code  = AluAdd;
                state_d   = StJal;
            end
            StJal: begin
                // PC <- target held in ALUOut while ALU forms the link value
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                alu_code  = AluAdd;
                pc_write  = 1'b1;
                state_d   = StAluWb;
            end
            StLui: begin
                alu_src_a = SrcAZero;
                alu_src_b = SrcBImm;
                imm_src   = ImmU;
                alu_code  = AluAdd;
                state_d   = StAluWb;
            end
            StIllegal: begin
                illegal = 1'b1;
                state_d = StFetch;
            end
            StTrap: begin
                illegal = 1'b1;
            end
            default: state_d = StFetch;
        endcase
    end

    // Outputs are forced low for as long as reset is held
    assign bus.mem_req     = rst_n & mem_req;
    assign bus.adr_src     = rst_n & adr_src;
    assign bus.mem_write   = rst_n & mem_write;
    assign bus.ir_write    = rst_n & ir_write;
    assign bus.pc_write    = rst_n & pc_write;
    assign bus.reg_write   = rst_n & reg_write;
    assign bus.illegal     = rst_n & illegal;
    assign bus.alu_src_a   = rst_n ? alu_src_a : 2'b00;
    assign bus.alu_src_b   = rst_n ? alu_src_b : 2'b00;
    assign bus.res_src     = rst_n ? res_src : 2'b00;
    assign bus.imm_src     = rst_n ? imm_src : 3'b000;
    assign bus.alu_control = rst_n ? ALUCW'(alu_code) : '0;
    assign bus.state_o     = rst_n ? state_q : 4'd0;
endmodule

// File: tb/tb_rv32_multicycle_controller.sv
// Bench for rv32_multicycle_controller: directed and random instructions
// checked cycle by cycle against a per-instruction expected control sequence.
module tb_rv32_multicycle_controller;

    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111;

    // Control word: {mem_req, adr_src, mem_write, ir_write, pc_write, reg_write,
    //                alu_src_a, alu_src_b, res_src, imm_src, alu_control, illegal}
    localparam logic [18:0] B_MR = 19'h40000, B_AD = 19'h20000, B_MW = 19'h10000;
    localparam logic [18:0] B_IRW = 19'h08000, B_PCW = 19'h04000, B_RW = 19'h02000;
    localparam logic [18:0] B_ILL = 19'h00001;

    logic        clk, rst_w, rst_z;
    logic [31:0] instr;
    logic        zero, lt, mem_ready;
    logic [18:0] obs_w, obs_z;
    int          vectors = 0;
    int          miscompares = 0;
    bit          mw_mode, trap_mode;
    logic [19:0] plan[$];

    logic [6:0] opcs    [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                7'b1101111, 7'b1100111, 7'b0110111, 7'h7F};
    logic [6:0] bad_opc [4] = '{7'h7F, 7'h00, 7'h17, 7'h73};
    logic [2:0] alu_f3  [5] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
    logic [2:0] br_f3   [4] = '{3'd0, 3'd1, 3'd4, 3'd5};

    rv32_multicycle_controller_if #(.ALUCW(3)) if_w ();
    rv32_multicycle_controller_if #(.ALUCW(3)) if_z ();

    rv32_multicycle_controller #(.MEM_WAIT(1'b1), .TRAP_ON_ILLEGAL(1'b1), .ALUCW(3)) dut_w (
        .clk   (clk),
        .rst_n (rst_w),
        .bus   (if_w.master)
    );

    rv32_multicycle_controller #(.MEM_WAIT(1'b0), .TRAP_ON_ILLEGAL(1'b0), .ALUCW(3)) dut_z (
        .clk   (clk),
        .rst_n (rst_z),
        .bus   (if_z.master)
    );

    assign if_w.instr = instr;
    assign if_w.zero = zero;
    assign if_w.lt = lt;
    assign if_w.mem_ready = mem_ready;
    assign if_z.instr = instr;
    assign if_z.zero = zero;
    assign if_z.lt = lt;
    assign if_z.mem_ready = mem_ready;

    assign obs_w = {if_w.mem_req, if_w.adr_src, if_w.mem_write, if_w.ir_write, if_w.pc_write,
                    if_w.reg_write, if_w.alu_src_a, if_w.alu_src_b, if_w.res_src, if_w.imm_src,
                    if_w.alu_control, if_w.illegal};
    assign obs_z = {if_z.mem_req, if_z.adr_src, if_z.mem_write, if_z.ir_write, if_z.pc_write,
                    if_z.reg_write, if_z.alu_src_a, if_z.alu_src_b, if_z.res_src, if_z.imm_src,
                    if_z.alu_control, if_z.illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed running, required done)");
        $fatal(1, "watchdog");
    end

    function automatic logic [18:0] mux(logic [1:0] a, logic [1:0] b, logic [1:0] res,
                                        logic [2:0] imm, logic [2:0] alu);
        return {6'b0, a, b, res, imm, alu, 1'b0};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(logic rdy, logic [18:0] w);
        plan.push_back({rdy, w});
    endfunction

    // Memory state: waits with ready low (honoured only when MEM_WAIT=1), then completion
    function automatic void push_mem(logic [18:0] w, int waits);
        if (mw_mode) for (int i = 0; i < waits; i++) push(1'b0, w);
        push(mw_mode ? 1'b1 : rb(), w);
    endfunction

    function automatic void push_ill();
        repeat (trap_mode ? 21 : 1) push(rb(), B_ILL);
    endfunction

    // Operation table: add/sub/slt/xor/or/and; anything else is unsupported
    function automatic void alu_ref(input logic [2:0] f3, input logic sub,
                                    output logic ok, output logic [2:0] code);
        ok = 1'b1;
        code = 3'd0;
        case (f3)
            3'd0:    code = sub ? 3'd6 : 3'd3;
            3'd2:    code = 3'd7;
            3'd4:    code = 3'd4;
            3'd6:    code = 3'd1;
            3'd7:    code = 3'd0;
            default: ok = 1'b0;
        endcase
        if (sub && f3 != 3'd0) begin
            ok = 1'b0;
            code = 3'd0;
        end
    endfunction

    function automatic void plan_instr(logic [31:0] ins, logic z, logic l, int fw, int mwt);
        logic [6:0]  opc;
        logic [2:0]  f3, code;
        logic        ok, tk;
        logic [18:0] wb, fetch, jal;
        opc   = ins[6:0];
        f3    = ins[14:12];
        wb    = B_RW;
        fetch = B_MR | mux(2'd0, 2'd2, 2'd2, 3'd0, 3'd3);
        jal   = B_PCW | mux(2'd1, 2'd2, 2'd0, 3'd0, 3'd3);
        if (mw_mode) for (int i = 0; i < fw; i++) push(1'b0, fetch);
        push(mw_mode ? 1'b1 : rb(), fetch | B_IRW | B_PCW);
        push(rb(), mux(2'd1, 2'd1, 2'd0, (opc == OP_JAL) ? 3'd3 : 3'd2, 3'd3));
        case (opc)
            OP_R, OP_I: begin
                alu_ref(f3, (opc == OP_R) && ins[30], ok, code);
                push(rb(), mux(2'd2, (opc == OP_R) ? 2'd0 : 2'd1, 2'd0, 3'd0, code));
                if (ok) push(rb(), wb);
                else push_ill();
            end
            OP_LD, OP_ST: begin
                push(rb(), mux(2'd2, 2'd1, 2'd0, (opc == OP_ST) ? 3'd1 : 3'd0, 3'd3));
                if (f3 != 3'd2) push_ill();
                else if (opc == OP_LD) begin
                    push_mem(B_MR | B_AD, mwt);
                    push(rb(), B_RW | mux(2'd0, 2'd0, 2'd1, 3'd0, 3'd0));
                end else push_mem(B_MR | B_AD | B_MW, mwt);
            end
            OP_BR: begin
                ok = 1'b1;
                tk = 1'b0;
                case (f3)
                    3'd0:    tk = z;
                    3'd1:    tk = !z;
                    3'd4:    tk = l;
                    3'd5:    tk = !l;
                    default: ok = 1'b0;
                endcase
                push(rb(), mux(2'd2, 2'd0, 2'd0, 3'd0, 3'd6) | (tk && ok ? B_PCW : 19'h0));
                if (!ok) push_ill();
            end
            OP_JAL: begin
                push(rb(), jal);
                push(rb(), wb);
            end
            OP_JALR: begin
                push(rb(), mux(2'd2, 2'd1, 2'd0, 3'd0, 3'd3));
                push(rb(), jal);
                push(rb(), wb);
            end
            OP_LUI: begin
                push(rb(), mux(2'd3, 2'd1, 2'd0, 3'd4, 3'd3));
                push(rb(), wb);
            end
            default: push_ill();
        endcase
    endfunction

    function automatic logic [31:0] gen_instr(bit legal_only);
        logic [31:0] ins;
        int          k;
        ins = $urandom();
        k   = legal_only ? $urandom_range(0, 7) : $urandom_range(0, 8);
        ins[6:0] = (k == 8) ? bad_opc[$urandom_range(0, 3)] : opcs[k];
        if (legal_only || rb()) begin
            case (k)
                0, 1: begin
                    ins[14:12] = alu_f3[$urandom_range(0, 4)];
                    if (k == 0 && ins[14:12] != 3'd0) ins[30] = 1'b0;
                end
                2, 3: ins[14:12] = 3'd2;
                4: ins[14:12] = br_f3[$urandom_range(0, 3)];
                default: ;
            endcase
        end
        return ins;
    endfunction

    task automatic check(input string tag, input logic [18:0] o, input logic [18:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Drives each planned cycle just after a rising edge; samples at the falling edge
    task automatic run_plan(input string tag, input bit use_z, input int max_n);
        logic [19:0] s;
        int          n;
        n = 0;
        while (plan.size() > 0 && n < max_n) begin
            s = plan.pop_front();
            mem_ready = s[19];
            @(negedge clk);
            check(tag, use_z ? obs_z : obs_w, s[18:0]);
            @(posedge clk);
            #1;
            n++;
        end
        plan.delete();
    endtask

    task automatic do_instr(input string tag, input logic [31:0] ins, input logic z,
                            input logic l, input int fw, input int mwt, input bit use_z);
        instr = ins;
        zero = z;
        lt = l;
        plan_instr(ins, z, l, fw, mwt);
        run_plan(tag, use_z, 1000);
    endtask

    initial begin
        rst_w = 1'b0;
        rst_z = 1'b0;
        instr = 32'h0;
        zero = 1'b0;
        lt = 1'b0;
        mem_ready = 1'b1;
        #3;
        check("reset_w", obs_w, 19'h0);
        check("reset_z", obs_z, 19'h0);
        check("reset_state", {15'h0, if_w.state_o}, 19'h0);
        @(posedge clk);
        #1;
        rst_w = 1'b1;

        // MEM_WAIT=1, TRAP_ON_ILLEGAL=1
        mw_mode = 1'b1;
        trap_mode = 1'b1;
        do_instr("add", 32'h002081B3, 1'b0, 1'b0, 0, 0, 1'b0);
        do_instr("lw_wait3", 32'h0080A283, 1'b0, 1'b0, 0, 3, 1'b0);
        do_instr("beq_taken", 32'h00208463, 1'b1, 1'b0, 0, 0, 1'b0);
        do_instr("bne_not", 32'h00209463, 1'b1, 1'b0, 0, 0, 1'b0);
        do_instr("jalr", 32'h000080E7, 1'b0, 1'b0, 1, 0, 1'b0);
        for (int i = 0; i < 60; i++)
            do_instr("rand_w", gen_instr(1'b1), rb(), rb(),
                     $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);

        // Reset while a store is waiting on memory
        instr = 32'h0020A223;
        plan_instr(instr, 1'b0, 1'b0, 0, 3);
        run_plan("sw_pre", 1'b0, 3);
        mem_ready = 1'b0;
        #1;
        check("sw_hold", obs_w, B_MR | B_AD | B_MW);
        rst_w = 1'b0;
        #1;
        check("sw_abort", obs_w, 19'h0);
        @(posedge clk);
        #1;
        rst_w = 1'b1;
        do_instr("after_abort", 32'h0080A283, 1'b0, 1'b0, 1, 1, 1'b0);

        do_instr("trap", 32'h0000007F, 1'b0, 1'b0, 0, 0, 1'b0);
        rst_w = 1'b0;
        #1;
        check("trap_reset", obs_w, 19'h0);
        @(posedge clk);
        #1;
        rst_w = 1'b1;
        do_instr("after_trap", 32'h00C0006F, 1'b0, 1'b0, 0, 0, 1'b0);

        // MEM_WAIT=0, TRAP_ON_ILLEGAL=0
        rst_w = 1'b0;
        rst_z = 1'b1;
        mw_mode = 1'b0;
        trap_mode = 1'b0;
        do_instr("add_z", 32'h002081B3, 1'b0, 1'b0, 0, 0, 1'b1);
        do_instr("lw_z", 32'h0080A283, 1'b0, 1'b0, 0, 0, 1'b1);
        do_instr("ill_z", 32'h0000007F, 1'b0, 1'b0, 0, 0, 1'b1);
        do_instr("lui_z", 32'h123452B7, 1'b0, 1'b0, 0, 0, 1'b1);
        for (int i = 0; i < 80; i++)
            do_instr("rand_z", gen_instr(1'b0), rb(), rb(), 0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
